// File: rtl/dr_assembler.sv
// dr_assembler: packs LSB-first UART bytes into DATA_PACKET_WIDTH-bit packets and pushes them to a FIFO.
// Define DR_TIMEOUT_EN to discard partial packets after TIMEOUT_CYCLES idle cycles in COLLECT.
module dr_assembler #(
    parameter int DATA_PACKET_WIDTH = 51,
    parameter int UART_DATA_WIDTH   = 8,
    parameter int TIMEOUT_CYCLES    = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [UART_DATA_WIDTH-1:0]   data_byte,
    input  logic                         we,
    input  logic                         f_full,
    output logic [DATA_PACKET_WIDTH-1:0] data_packet,
    output logic                         wr_en,
    output logic                         overflow,
    output logic                         timeout
);
    localparam int NBYTES = (DATA_PACKET_WIDTH + UART_DATA_WIDTH - 1) / UART_DATA_WIDTH;
    localparam int BW     = NBYTES * UART_DATA_WIDTH;
    localparam int CW     = $clog2(NBYTES + 1);
    typedef enum logic [1:0] {IDLE, COLLECT, PUSH} state_t;
    state_t                       state_q;
    logic [CW-1:0]                count_q;
    logic [BW-1:0]                buf_q;
    logic [BW-1:0]                buf_d;
    logic [DATA_PACKET_WIDTH-1:0] data_packet_q;
    logic                         overflow_q;
    // count_q is 0 in IDLE and PUSH, so buf_d always lands a fresh byte 0 there
    always_comb begin
        buf_d = buf_q;
        buf_d[int'(count_q) * UART_DATA_WIDTH +: UART_DATA_WIDTH] = data_byte;
    end
`ifdef DR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tcnt_q;
    logic          timeout_q;
    logic          expire;
    assign expire  = state_q == COLLECT && !we && tcnt_q == TW'(TIMEOUT_CYCLES - 1);
    assign timeout = timeout_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            tcnt_q    <= (state_q == COLLECT && !we && !expire) ? tcnt_q + 1'b1 : '0;
            timeout_q <= expire;
        end
    end
`else
    logic expire;
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            count_q       <= '0;
            buf_q         <= '0;
            data_packet_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (we) begin
                    buf_q   <= buf_d;
                    count_q <= CW'(1);
                    state_q <= COLLECT;
                end
                COLLECT: if (we) begin
                    buf_q <= buf_d;
                    if (count_q == CW'(NBYTES - 1)) begin
                        data_packet_q <= buf_d[DATA_PACKET_WIDTH-1:0];
                        count_q       <= '0;
                        state_q       <= PUSH;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end else if (expire) begin
                    count_q <= '0;
                    state_q <= IDLE;
                end
                PUSH: if (!f_full) begin
                    if (we) begin
                        buf_q   <= buf_d;
                        count_q <= CW'(1);
                        state_q <= COLLECT;
                    end else begin
                        state_q <= IDLE;
                    end
                end else if (we) begin
                    overflow_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign wr_en       = state_q == PUSH && !f_full;
    assign data_packet = data_packet_q;
    assign overflow    = overflow_q;
endmodule

// File: tb/tb_dr_assembler.sv
// tb_dr_assembler: table vectors, directed corner sequences and random traffic checked against a queue-based model.
module tb_dr_assembler;
    localparam int DW = 51;
    localparam int NB = 7;
    localparam int TO = 10;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    data_byte = '0;
    logic          we = 1'b0;
    logic          f_full = 1'b0;
    logic [DW-1:0] data_packet;
    logic          wr_en, overflow, timeout;
    int n_pass = 0;
    int n_tot  = 0;

    dr_assembler #(.DATA_PACKET_WIDTH(DW), .UART_DATA_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .data_byte(data_byte), .we(we), .f_full(f_full),
        .data_packet(data_packet), .wr_en(wr_en), .overflow(overflow), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // reference model: bytes gathered so far, one pending packet, sticky drop flag
    logic [7:0]    mq[$];
    bit            pending = 0;
    logic [DW-1:0] pkt = '0;
    bit            ovf = 0;
    bit            tout = 0;
    bit            just_reset = 1;
    int            idle = 0;

    typedef struct {
        bit            w;
        logic [7:0]    b;
        bit            ff;
        bit            ew;
        bit            eo;
        bit            cd;
        logic [DW-1:0] ed;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    endtask

    function automatic vec_t mk(bit w, logic [7:0] b, bit ff, bit ew, bit eo, bit cd, logic [DW-1:0] ed);
        vec_t v;
        v.w = w; v.b = b; v.ff = ff; v.ew = ew; v.eo = eo; v.cd = cd; v.ed = ed;
        return v;
    endfunction

    function automatic logic [DW-1:0] pack();
        logic [63:0] acc = '0;
        foreach (mq[k]) acc |= 64'(mq[k]) << (8 * k);
        return acc[DW-1:0];
    endfunction

    task automatic model_check();
        chk("wr_en", 64'(wr_en), 64'(pending && !f_full));
        chk("overflow", 64'(overflow), 64'(ovf));
        chk("timeout", 64'(timeout), 64'(tout));
        if (pending || just_reset) chk("data_packet", 64'(data_packet), pending ? 64'(pkt) : 64'd0);
    endtask

    task automatic model_step();
        if (rst) begin
            mq.delete(); pending = 0; ovf = 0; tout = 0; idle = 0; just_reset = 1;
        end else begin
            just_reset = 0;
            tout = 0;
            if (pending) begin
                if (!f_full) begin
                    pending = 0;
                    if (we) begin mq.push_back(data_byte); idle = 0; end
                end else if (we) ovf = 1;
            end else if (we) begin
                mq.push_back(data_byte);
                idle = 0;
                if (mq.size() == NB) begin pkt = pack(); pending = 1; mq.delete(); end
            end else if (mq.size() != 0) begin
`ifdef DR_TIMEOUT_EN
                idle++;
                if (idle == TO) begin mq.delete(); idle = 0; tout = 1; end
`endif
            end
        end
    endtask

    task automatic half(input bit r, input bit w, input logic [7:0] b, input bit ff);
        rst = r; we = w; data_byte = b; f_full = ff;
        @(negedge clk);
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cycle(input bit r, input bit w, input logic [7:0] b, input bit ff);
        half(r, w, b, ff);
        tick();
    endtask

    initial begin
        int nwr, nto;
        for (int k = 0; k < NB; k++) tv.push_back(mk(1, 8'(k + 1), 0, 0, 0, 0, '0));
        tv.push_back(mk(0, 0, 0, 1, 0, 1, 51'h7060504030201));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, '0));
        for (int k = 0; k < NB; k++) tv.push_back(mk(1, 8'hFF, 0, 0, 0, 0, '0));
        tv.push_back(mk(0, 0, 0, 1, 0, 1, 51'h7FFFFFFFFFFFF));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, '0));
        for (int k = 0; k < NB; k++) tv.push_back(mk(1, 8'(8'h10 + k), 0, 0, 0, 0, '0));
        tv.push_back(mk(0, 0, 1, 0, 0, 1, 51'h6151413121110));
        tv.push_back(mk(0, 0, 1, 0, 0, 1, 51'h6151413121110));
        tv.push_back(mk(1, 8'h99, 1, 0, 0, 1, 51'h6151413121110));
        tv.push_back(mk(0, 0, 1, 0, 1, 1, 51'h6151413121110));
        tv.push_back(mk(0, 0, 1, 0, 1, 1, 51'h6151413121110));
        tv.push_back(mk(0, 0, 0, 1, 1, 1, 51'h6151413121110));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, '0));

        @(posedge clk); #1;
        cycle(1, 1, 8'hAA, 0);
        half(0, 0, 0, 0);
        chk("rst_wr_en", 64'(wr_en), 0);
        chk("rst_data_packet", 64'(data_packet), 0);
        chk("rst_overflow", 64'(overflow), 0);
        chk("rst_timeout", 64'(timeout), 0);
        tick();

        foreach (tv[i]) begin
            half(0, tv[i].w, tv[i].b, tv[i].ff);
            chk("tbl_wr_en", 64'(wr_en), 64'(tv[i].ew));
            chk("tbl_overflow", 64'(overflow), 64'(tv[i].eo));
            if (tv[i].cd) chk("tbl_data_packet", 64'(data_packet), 64'(tv[i].ed));
            tick();
        end

        cycle(1, 0, 0, 0);
        nwr = 0;
        for (int i = 0; i < 2 * NB + 3; i++) begin
            half(0, i < 2 * NB, 8'(8'h21 + i), 0);
            if (wr_en) nwr++;
            tick();
        end
        chk("b2b_wr_count", 64'(nwr), 2);
        chk("b2b_overflow", 64'(overflow), 0);

        cycle(1, 0, 0, 0);
        nwr = 0; nto = 0;
        for (int i = 0; i < 3 + 3 * TO; i++) begin
            half(0, i < 3, 8'(8'h40 + i), 0);
            if (wr_en) nwr++;
            if (timeout) nto++;
            tick();
        end
`ifdef DR_TIMEOUT_EN
        chk("timeout_pulses", 64'(nto), 1);
`else
        chk("timeout_pulses", 64'(nto), 0);
`endif
        chk("timeout_no_wr", 64'(nwr), 0);
        for (int i = 0; i < NB; i++) cycle(0, 1, 8'(8'h50 + i), 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);

        cycle(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 8'(8'h60 + i), 0);
        cycle(1, 1, 8'h77, 0);
        half(0, 0, 0, 0);
        chk("rst_mid_wr_en", 64'(wr_en), 0);
        chk("rst_mid_data_packet", 64'(data_packet), 0);
        chk("rst_mid_overflow", 64'(overflow), 0);
        tick();
        for (int i = 0; i < NB; i++) cycle(0, 1, 8'(8'h70 + i), 1);
        cycle(0, 1, 8'h55, 1);
        cycle(1, 0, 0, 1);
        half(0, 0, 0, 0);
        chk("rst_push_wr_en", 64'(wr_en), 0);
        chk("rst_push_data_packet", 64'(data_packet), 0);
        chk("rst_push_overflow", 64'(overflow), 0);
        tick();
        for (int i = 0; i < NB; i++) cycle(0, 1, 8'(8'h80 + i), 0);
        half(0, 0, 0, 0);
        chk("post_rst_wr_en", 64'(wr_en), 1);
        chk("post_rst_packet", 64'(data_packet), 64'(51'h6858483828180));
        tick();

        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(199) == 0, $urandom_range(9) < 6, 8'($urandom), $urandom_range(9) < 3);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/dr_assembler.md
DR_ASSEMBLER -- requirements
Module: dr_assembler

Interface
REQ-001 Parameter DATA_PACKET_WIDTH, default 51: width of each assembled packet.
REQ-002 Parameter UART_DATA_WIDTH, default 8: width of each received byte.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000: inter-byte idle limit in clk cycles, minimum 2.
REQ-004 clk  input  1: single clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 data_byte  input  UART_DATA_WIDTH: received byte.
REQ-007 we  input  1: data_byte valid for this cycle.
REQ-008 f_full  input  1: downstream FIFO full.
REQ-009 data_packet  output  DATA_PACKET_WIDTH: assembled packet.
REQ-010 wr_en  output  1: one-cycle FIFO write strobe for data_packet.
REQ-011 overflow  output  1: sticky flag, set when a byte is dropped.
REQ-012 timeout  output  1: one-cycle pulse when a partial packet is discarded.

Function
REQ-013 NBYTES SHALL be ceil(DATA_PACKET_WIDTH/UART_DATA_WIDTH): 7 at default values.
REQ-014 Byte order SHALL be least-significant first; byte k fills bits [8k+7:8k]; bits above DATA_PACKET_WIDTH-1 in the last byte SHALL be discarded.
REQ-015 The FSM SHALL have three states. IDLE waits for the first byte. COLLECT holds bytes 1..NBYTES-1. PUSH holds a complete packet.
REQ-016 IDLE with we: store byte 0, set count to 1, and go to COLLECT.
REQ-017 COLLECT with we: store the byte at the count position and increment count; on byte NBYTES-1, load data_packet and go to PUSH.
REQ-018 wr_en SHALL equal (state==PUSH && !f_full), which gives a latency of 1 cycle after the last byte's accepting edge when the FIFO is not full.
REQ-019 PUSH with !f_full SHALL return to IDLE; a we in the same cycle SHALL be accepted as byte 0 of the next packet (go to COLLECT, count 1).
REQ-020 PUSH with f_full SHALL hold state and data_packet; a we in that cycle SHALL drop the byte and set overflow.
REQ-021 data_packet SHALL stay stable from entry into PUSH until the cycle after wr_en.
REQ-022 overflow SHALL clear only on rst.

Reset
REQ-023 On rst: state IDLE, count 0, data_packet 0, wr_en 0, overflow 0, timeout 0, timeout counter 0.
REQ-024 rst SHALL take priority over every event, including we and a PUSH in progress.
REQ-025 A partial or pending packet at reset SHALL be discarded with no wr_en.

Configuration
REQ-026 Macro DR_TIMEOUT_EN, when defined, SHALL enable the inter-byte timeout.
- In COLLECT, a counter SHALL clear on each accepted byte and increment otherwise.
- When the counter reaches TIMEOUT_CYCLES-1 with no we, the partial packet SHALL be discarded, the FSM SHALL go to IDLE, and timeout SHALL pulse for 1 cycle.
- A we on the expiry cycle SHALL win: the byte is accepted and no timeout occurs.
REQ-027 Without DR_TIMEOUT_EN, no counter SHALL be built, timeout SHALL be tied 0, and COLLECT SHALL wait indefinitely.
REQ-028 IDLE and PUSH SHALL never time out.

Verification
REQ-029 Seven back-to-back bytes 0x01..0x07 with f_full=0 -> wr_en high exactly 1 cycle after the 7th byte; data_packet=0x07_0605_0403_0201 truncated to 51 bits (0x7_0605_0403_0201); overflow=0.
REQ-030 Seven bytes 0xFF -> data_packet=51'h7_FFFF_FFFF_FFFF (top 5 bits dropped).
REQ-031 f_full=1 for 5 cycles after the 7th byte, with one byte sent during that window -> wr_en held low, then high for 1 cycle after f_full falls; data_packet unchanged; overflow=1 sticky.
REQ-032 14 contiguous bytes, with byte 8 arriving in the wr_en cycle -> two wr_en pulses and two correct packets, no overflow.
REQ-033 With DR_TIMEOUT_EN and TIMEOUT_CYCLES=10: 3 bytes then idle -> timeout pulses once, no wr_en; the next 7 bytes form a clean packet. Without the macro -> timeout stays 0.
REQ-034 rst asserted after 4 bytes and while in PUSH -> all outputs 0 the next cycle, no wr_en; the following 7 bytes assemble correctly.
